axis_pkt_gen: RTL

- Programmable AXI-Stream packet generator, the transmit-side counterpart of the UDP/CMAC receive monitoring path.
- Emits numbered test packets of configurable size and inter-packet gap on a 512-bit AXI-Stream master.
- Sits in the xdma_axi_aclk domain and feeds the CMAC TX buffer.
- Exposes beat, packet and cycle counters so throughput can be probed by ILA.

---
 rtl/axis_pkt_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_gen.sv
// AXI-Stream test packet generator: numbered packets of programmable size and gap,
// with run counters for throughput probing.
module axis_pkt_gen #(
  parameter int          TDATA_WIDTH       = 512,
  parameter int          TKEEP_WIDTH       = TDATA_WIDTH / 8,
  parameter int          TUSER_WIDTH       = 1,
  // Value cycle_count is loaded with at start; nonzero only to exercise saturation.
  parameter logic [31:0] CYCLE_COUNT_START = 32'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            pkt_size,
  input  logic [31:0]            pkt_interval,
  input  logic [31:0]            pkt_num,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   busy,
  output logic [31:0]            sent_pkt_count,
  output logic [31:0]            sent_beat_count,
  output logic [31:0]            cycle_count,
  output logic                   cycle_count_full
);

  localparam int NWORDS = TDATA_WIDTH / 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] size_q, size_d;
  logic [31:0] interval_q, interval_d;
  logic [31:0] num_q, num_d;
  logic [10:0] nbeats_q, nbeats_d;
  logic [10:0] beat_q, beat_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] gap_q, gap_d;
  logic        stop_pend_q, stop_pend_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic        cyc_full_q, cyc_full_d;

  logic        sending;
  logic        last_beat;
  logic        handshake;
  logic [31:0] pkt_cnt_inc;

  assign sending     = (state_q == SEND);
  assign last_beat   = (beat_q == nbeats_q - 11'd1);
  assign handshake   = sending && m_axis_tready;
  assign pkt_cnt_inc = pkt_cnt_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      interval_q  <= '0;
      num_q       <= '0;
      nbeats_q    <= 11'd1;
      beat_q      <= '0;
      seq_q       <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      pkt_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      cyc_q       <= '0;
      cyc_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      interval_q  <= interval_d;
      num_q       <= num_d;
      nbeats_q    <= nbeats_d;
      beat_q      <= beat_d;
      seq_q       <= seq_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      pkt_cnt_q   <= pkt_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      cyc_q       <= cyc_d;
      cyc_full_q  <= cyc_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    interval_d  = interval_q;
    num_d       = num_q;
    nbeats_d    = nbeats_q;
    beat_d      = beat_q;
    seq_d       = seq_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    pkt_cnt_d   = pkt_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    cyc_d       = cyc_q;
    cyc_full_d  = cyc_full_q;

    // Busy-cycle counter sticks at all ones once it gets there.
    if (state_q != IDLE) begin
      if (cyc_q != 32'hFFFF_FFFF) begin
        cyc_d = cyc_q + 32'd1;
      end
      if (cyc_d == 32'hFFFF_FFFF) begin
        cyc_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && (pkt_size != 16'd0)) begin
          state_d     = SEND;
          size_d      = pkt_size;
          interval_d  = pkt_interval;
          num_d       = pkt_num;
          nbeats_d    = 11'((17'(pkt_size) + 17'd63) >> 6);
          beat_d      = '0;
          seq_d       = '0;
          stop_pend_d = 1'b0;
          pkt_cnt_d   = '0;
          beat_cnt_d  = '0;
          cyc_d       = CYCLE_COUNT_START;
          cyc_full_d  = 1'b0;
        end
      end

      SEND: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (handshake) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          if (last_beat) begin
            pkt_cnt_d = pkt_cnt_inc;
            seq_d     = seq_q + 16'd1;
            beat_d    = '0;
            // A stop seen on the closing beat itself also ends the run here.
            if (((num_q != 32'd0) && (pkt_cnt_inc == num_q)) || stop_pend_q || stop) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end else if (interval_q != 32'd0) begin
              state_d = GAP;
              gap_d   = interval_q;
            end
          end else begin
            beat_d = beat_q + 11'd1;
          end
        end
      end

      GAP: begin
        if (stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else if (gap_q <= 32'd1) begin
          state_d = SEND;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output path is driven purely from state flops; tready never reaches tvalid.
  logic [5:0]             rem_bytes;
  logic [TKEEP_WIDTH-1:0] tail_mask;
  logic [TKEEP_WIDTH-1:0] keep;
  logic [TDATA_WIDTH-1:0] raw_data;

  assign rem_bytes = size_q[5:0];

  genvar gi;
  generate
    for (gi = 0; gi < TKEEP_WIDTH; gi++) begin : g_tail_mask
      assign tail_mask[gi] = (7'(gi) < {1'b0, rem_bytes});
    end

    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      assign raw_data[32*gi +: 32] = {seq_q, 1'b0, beat_q, 4'(gi)};
    end

    // Disabled byte lanes read as zero, and the whole bus is zero when idle.
    for (gi = 0; gi < TKEEP_WIDTH; gi++) begin : g_bytes
      assign m_axis_tdata[8*gi +: 8] = keep[gi] ? raw_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    keep = '0;
    if (sending) begin
      if (last_beat && (rem_bytes != 6'd0)) begin
        keep = tail_mask;
      end else begin
        keep = '1;
      end
    end
  end

  assign m_axis_tvalid    = sending;
  assign m_axis_tkeep     = keep;
  assign m_axis_tlast     = sending && last_beat;
  assign m_axis_tuser     = '0;
  assign busy             = (state_q != IDLE);
  assign sent_pkt_count   = pkt_cnt_q;
  assign sent_beat_count  = beat_cnt_q;
  assign cycle_count      = cyc_q;
  assign cycle_count_full = cyc_full_q;

endmodule
